// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port 16x8 RAM between a CPU port (A) and a
// loader/IO port (B). Each transaction is one IDLE grant cycle, one ACCESS
// cycle driving the RAM, and one RESP cycle pulsing the granted port's ack.
// Port A is held off until the loader signals load_done (cpu_run).
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   a_req/a_we/a_addr/a_wdata    CPU request, direction, address, write data
//   a_ack/a_rdata                CPU completion pulse, registered read data
//   b_req/b_we/b_addr/b_wdata    loader request, direction, address, write data
//   b_ack/b_rdata                loader completion pulse, registered read data
//   load_done                    loader pulse: program image complete
//   cpu_run                      CPU enable, sticky until reset
//   ram_*                        connection to ram_16x8
//   busy                         high whenever not IDLE
//
// state  | meaning
// IDLE   | waiting for an eligible request; grants and captures on request
// ACCESS | RAM driven with captured addr/data for one cycle
// RESP   | ack pulse to the granted port, then back to IDLE

module ram_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  input  logic       load_done,
  output logic       cpu_run,
  output logic [3:0] ram_address,
  output logic [7:0] ram_data_in,
  output logic       ram_read_enable,
  output logic       ram_write_enable,
  input  logic [7:0] ram_data_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  // g_sel / last_grant: 0 = port A, 1 = port B
  logic       g_sel_q, g_sel_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] a_rdata_q, a_rdata_d;
  logic [7:0] b_rdata_q, b_rdata_d;
  logic       cpu_run_q, cpu_run_d;

  logic       a_elig;
  logic       sel_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      g_sel_q      <= 1'b0;
      last_grant_q <= 1'b1;  // B, so A wins the first tie
      addr_q       <= 4'h0;
      we_q         <= 1'b0;
      wdata_q      <= 8'h00;
      a_rdata_q    <= 8'h00;
      b_rdata_q    <= 8'h00;
      cpu_run_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      g_sel_q      <= g_sel_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      cpu_run_q    <= cpu_run_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    g_sel_d          = g_sel_q;
    last_grant_d     = last_grant_q;
    addr_d           = addr_q;
    we_d             = we_q;
    wdata_d          = wdata_q;
    a_rdata_d        = a_rdata_q;
    b_rdata_d        = b_rdata_q;
    cpu_run_d        = cpu_run_q | load_done;
    a_ack            = 1'b0;
    b_ack            = 1'b0;
    ram_address      = 4'h0;
    ram_data_in      = 8'h00;
    ram_read_enable  = 1'b0;
    ram_write_enable = 1'b0;

    // Eligibility uses the registered cpu_run: the load_done edge itself
    // cannot also grant port A.
    a_elig = a_req & cpu_run_q;
    // B wins when it is the only requester, or on a tie when A was last.
    sel_b  = b_req & (~a_elig | ~last_grant_q);

    case (state_q)
      S_IDLE: begin
        if (a_elig | b_req) begin
          g_sel_d      = sel_b;
          last_grant_d = sel_b;
          addr_d       = sel_b ? b_addr  : a_addr;
          we_d         = sel_b ? b_we    : a_we;
          wdata_d      = sel_b ? b_wdata : a_wdata;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ram_address = addr_q;
        if (we_q) begin
          ram_write_enable = 1'b1;
          ram_data_in      = wdata_q;
        end else begin
          ram_read_enable = 1'b1;
          if (g_sel_q) b_rdata_d = ram_data_out;
          else         a_rdata_d = ram_data_out;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        a_ack   = ~g_sel_q;
        b_ack   = g_sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign cpu_run = cpu_run_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16x8 RAM attached.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we, load_done;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, b_ack, cpu_run, busy;
  logic [7:0] a_rdata, b_rdata;
  logic [3:0] ram_address;
  logic [7:0] ram_data_in, ram_data_out;
  logic       ram_read_enable, ram_write_enable;

  logic [7:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .a_req            (a_req),
    .a_we             (a_we),
    .a_addr           (a_addr),
    .a_wdata          (a_wdata),
    .a_ack            (a_ack),
    .a_rdata          (a_rdata),
    .b_req            (b_req),
    .b_we             (b_we),
    .b_addr           (b_addr),
    .b_wdata          (b_wdata),
    .b_ack            (b_ack),
    .b_rdata          (b_rdata),
    .load_done        (load_done),
    .cpu_run          (cpu_run),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out),
    .busy             (busy)
  );

  // ram_16x8 model: combinational read, write on rising edge
  assign ram_data_out = ram_read_enable ? mem[ram_address] : 8'h00;
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 8'(busy), 8'h0);
    chk({tag, "_cpu_run"}, 8'(cpu_run), 8'h0);
    chk({tag, "_a_ack"}, 8'(a_ack), 8'h0);
    chk({tag, "_b_ack"}, 8'(b_ack), 8'h0);
    chk({tag, "_a_rdata"}, a_rdata, 8'h00);
    chk({tag, "_b_rdata"}, b_rdata, 8'h00);
    chk({tag, "_rd_en"}, 8'(ram_read_enable), 8'h0);
    chk({tag, "_wr_en"}, 8'(ram_write_enable), 8'h0);
    chk({tag, "_addr"}, 8'(ram_address), 8'h0);
    chk({tag, "_din"}, ram_data_in, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_req = 1'b0; b_req = 1'b0; load_done = 1'b0;
    #1;
    check_reset_state("rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Single transaction from an idle arbiter, checking every cycle of it.
  task automatic do_xfer(input bit pb, input bit we, input logic [3:0] addr,
                         input logic [7:0] wd, input bit ld);
    if (pb) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    @(posedge clk); #1;
    chk("acc_wr_en", 8'(ram_write_enable), 8'(we));
    chk("acc_rd_en", 8'(ram_read_enable), 8'(!we));
    chk("acc_addr", 8'(ram_address), 8'(addr));
    if (we) chk("acc_din", ram_data_in, wd);
    chk("acc_busy", 8'(busy), 8'h1);
    chk("acc_a_ack", 8'(a_ack), 8'h0);
    chk("acc_b_ack", 8'(b_ack), 8'h0);
    load_done = ld;
    @(posedge clk); #1;
    load_done = 1'b0;
    chk("resp_a_ack", 8'(a_ack), 8'(!pb));
    chk("resp_b_ack", 8'(b_ack), 8'(pb));
    chk("resp_wr_en", 8'(ram_write_enable), 8'h0);
    chk("resp_rd_en", 8'(ram_read_enable), 8'h0);
    if (pb) b_req = 1'b0;
    else    a_req = 1'b0;
    @(posedge clk); #1;
    chk("idle_a_ack", 8'(a_ack), 8'h0);
    chk("idle_b_ack", 8'(b_ack), 8'h0);
    chk("idle_busy", 8'(busy), 8'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    a_we = 1'b0; a_addr = 4'h0; a_wdata = 8'h00;
    b_we = 1'b0; b_addr = 4'h0; b_wdata = 8'h00;
    do_reset();

    // B write 0x3 <- 0xA5, then B read it back
    do_xfer(1'b1, 1'b1, 4'h3, 8'hA5, 1'b0);
    do_xfer(1'b1, 1'b0, 4'h3, 8'h00, 1'b0);
    chk("b_read_3", b_rdata, 8'hA5);
    chk("a_rdata_untouched", a_rdata, 8'h00);

    // A is ignored while cpu_run is low
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'h3;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("held_a_ack", 8'(a_ack), 8'h0);
      chk("held_rd_en", 8'(ram_read_enable), 8'h0);
      chk("held_wr_en", 8'(ram_write_enable), 8'h0);
    end
    load_done = 1'b1;
    @(posedge clk); #1;
    load_done = 1'b0;
    chk("cpu_run_set", 8'(cpu_run), 8'h1);
    chk("no_grant_on_load_edge", 8'(busy), 8'h0);
    do_xfer(1'b0, 1'b0, 4'h3, 8'h00, 1'b0);
    chk("a_read_3", a_rdata, 8'hA5);

    // Address extremes
    do_xfer(1'b0, 1'b1, 4'hF, 8'hFF, 1'b0);
    chk("a_rdata_after_write", a_rdata, 8'hA5);
    do_xfer(1'b0, 1'b0, 4'hF, 8'h00, 1'b0);
    chk("a_read_F", a_rdata, 8'hFF);
    do_xfer(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    chk("a_read_0", a_rdata, 8'h00);
    chk("b_rdata_kept", b_rdata, 8'hA5);

    // Continuous contention; A was granted last so B goes first
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'h3;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      begin
        bit exp_b;
        exp_b = ((k / 3) % 2) == 0;
        chk("rr_a_ack", 8'(a_ack), 8'((k % 3 == 2) && !exp_b));
        chk("rr_b_ack", 8'(b_ack), 8'((k % 3 == 2) && exp_b));
        chk("rr_rd_en", 8'(ram_read_enable), 8'(k % 3 == 1));
        if (k % 3 == 1) chk("rr_addr", 8'(ram_address), exp_b ? 8'h0F : 8'h03);
        chk("rr_excl", 8'(ram_read_enable & ram_write_enable), 8'h0);
      end
      if (k == 11) begin
        a_req = 1'b0; b_req = 1'b0;
      end
    end
    chk("rr_busy_end", 8'(busy), 8'h0);
    chk("rr_a_rdata", a_rdata, 8'hA5);
    chk("rr_b_rdata", b_rdata, 8'hFF);

    // Reset in the middle of an ACCESS write
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'h7; b_wdata = 8'h3C;
    @(posedge clk); #1;
    chk("pre_rst_wr_en", 8'(ram_write_enable), 8'h1);
    chk("pre_rst_addr", 8'(ram_address), 8'h07);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("mid_rst");
    b_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_b_ack", 8'(b_ack), 8'h0);
      chk("post_rst_busy", 8'(busy), 8'h0);
    end

    // load_done arriving mid-transfer
    do_xfer(1'b1, 1'b0, 4'h3, 8'h00, 1'b1);
    chk("ld_busy_cpu_run", 8'(cpu_run), 8'h1);
    chk("ld_busy_b_rdata", b_rdata, 8'hA5);

    // First tie after reset goes to A
    do_reset();
    load_done = 1'b1;
    @(posedge clk); #1;
    load_done = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'hF;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'h3;
    @(posedge clk); #1;
    chk("tie_first_addr", 8'(ram_address), 8'h0F);
    @(posedge clk); #1;
    chk("tie_a_ack", 8'(a_ack), 8'h1);
    chk("tie_b_ack0", 8'(b_ack), 8'h0);
    a_req = 1'b0;
    @(posedge clk); #1;
    chk("tie_idle", 8'(busy), 8'h0);
    @(posedge clk); #1;
    chk("tie_second_addr", 8'(ram_address), 8'h03);
    @(posedge clk); #1;
    chk("tie_b_ack", 8'(b_ack), 8'h1);
    b_req = 1'b0;
    @(posedge clk); #1;
    chk("tie_done_busy", 8'(busy), 8'h0);
    chk("tie_a_rdata", a_rdata, 8'hFF);
    chk("tie_b_rdata", b_rdata, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 a_req, a_we  input  1 each  CPU port: access request; write (1) / read (0).
REQ-004 a_addr, a_wdata  input  4, 8  CPU port: word address; write data.
REQ-005 a_ack  output  1  CPU port: one-cycle completion pulse.
REQ-006 a_rdata  output  8  CPU port: registered read data.
REQ-007 b_req, b_we  input  1 each  loader/IO port: request; write/read.
REQ-008 b_addr, b_wdata  input  4, 8  loader port: address; write data.
REQ-009 b_ack  output  1  loader port: one-cycle completion pulse.
REQ-010 b_rdata  output  8  loader port: registered read data.
REQ-011 load_done  input  1  loader pulse: program image complete.
REQ-012 cpu_run  output  1  CPU enable (drives the core's active input).
REQ-013 ram_address, ram_data_in  output  4, 8  to ram_16x8 address/data_in.
REQ-014 ram_read_enable, ram_write_enable  output  1 each  to ram_16x8 enables.
REQ-015 ram_data_out  input  8  from ram_16x8; combinational, valid while ram_read_enable=1.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; exactly one state active.
REQ-018 IDLE: no request -> stay; any request -> grant latched (g_sel), port's addr/we/wdata captured into internal registers, go to ACCESS.
REQ-019 Arbitration: only one request -> that port wins; both requesting -> port not granted last (last_grant) wins; last_grant updates on every grant.
REQ-020 A request from port A is ignored (not granted, a_ack stays 0) while cpu_run=0; B is always eligible.
REQ-021 ACCESS (exactly 1 cycle): ram_address = captured addr; write -> ram_write_enable=1, ram_data_in = captured wdata, ram_read_enable=0; read -> ram_read_enable=1, ram_write_enable=0, ram_data_out registered at end of cycle into granted port's rdata.
REQ-022 Outside ACCESS: ram_read_enable=0, ram_write_enable=0, ram_address=0, ram_data_in=0.
REQ-023 RESP (exactly 1 cycle): granted port's ack=1, other ack=0; next state IDLE.
REQ-024 Latency: request seen in IDLE at edge N -> ACCESS cycle N+1 -> ack high cycle N+2; next grant no earlier than cycle N+3.
REQ-025 Requesters hold req/addr/we/wdata stable until ack, then drop req in the ack cycle; a req still high in the IDLE cycle after RESP is a new request.
REQ-026 Inputs changing during ACCESS/RESP do not affect the transaction in flight (captured values only).
REQ-027 rdata of a port holds its value until that port's next read; writes do not modify rdata.
REQ-028 cpu_run: set to 1 on the first edge where load_done=1; thereafter remains 1 until reset; load_done while busy sets cpu_run without disturbing the transfer.
REQ-029 At most one ram enable high in any cycle; never both.

Reset
REQ-030 Reset asserted (any time, incl. mid-ACCESS) -> immediately: state IDLE, a_ack=b_ack=0, a_rdata=b_rdata=0x00, all ram_* outputs 0, busy=0, cpu_run=0, last_grant=B (A wins first tie).
REQ-031 Transaction interrupted by reset is abandoned: no ack after reset release; RAM contents undefined only for the aborted write address.
REQ-032 First grant possible on the first rising edge after reset deasserts.

Verification
REQ-033 Reset, B write addr 0x3 data 0xA5 -> ram_write_enable=1, ram_address=0x3 for one cycle, b_ack pulse two cycles after request.
REQ-034 B read 0x3 after that write -> b_rdata=0xA5 at b_ack, a_rdata unchanged 0x00.
REQ-035 a_req high with cpu_run=0 for 10 cycles -> no a_ack, no RAM enables; pulse load_done -> cpu_run=1, then A request granted.
REQ-036 cpu_run=1, A and B request simultaneously and continuously -> grants alternate A,B,A,B; each ack every 3 cycles.
REQ-037 Reset asserted during ACCESS of B write 0x7/0x3C -> enables drop same cycle, no b_ack, busy=0, cpu_run=0.
REQ-038 Write 0xFF to 0xF, then read 0xF and 0x0 from A -> a_rdata 0xFF then 0x00 (no wrap or aliasing across 4-bit address).
